// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the parametrised Gray counter.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 16;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR from the MSB downwards (zero-extended inputs are safe).
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_next_logic.sv
// Next-state logic for the Gray counter: load / up / down step with wrap or saturate.
//   cnt        current binary count
//   up_down    direction (1 = up)
//   enable     step request
//   load       parallel-load request (wins over enable)
//   load_value binary value to load
//   cnt_next   next binary count
//   term_next  terminal event (wrap or blocked saturation step) on this step
module gray_next_logic
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 5,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up_down,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] cnt_next,
  output logic             term_next
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Step selection; at either end of range the step is terminal and either wraps or holds.
  always_comb begin
    cnt_next  = cnt;
    term_next = 1'b0;
    if (load) begin
      cnt_next = load_value;
    end else if (enable) begin
      if (up_down) begin
        if (cnt == MAX_VAL) begin
          term_next = 1'b1;
          if (!SATURATE) cnt_next = '0;
        end else begin
          cnt_next = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
          term_next = 1'b1;
          if (!SATURATE) cnt_next = MAX_VAL;
        end else begin
          cnt_next = cnt - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with parallel load, wrap/saturate mode,
// registered binary mirror and terminal-event pulse.
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   enable     count-step request
//   up_down    direction (1 = up), sampled with the step
//   load       synchronous parallel load
//   load_value binary value to load
//   gray_out   registered Gray count
//   bin_out    registered binary count
//   at_limit   combinational: count at end of range for the live direction
//   term_pulse registered one-cycle pulse per wrap or blocked saturation step
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             at_limit,
  output logic             term_pulse
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VALUE)));

  // Elaboration-time parameter checks.
  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("gray_counter_param: WIDTH must be in 2..16");
  end
  if (RESET_VALUE >= (32'd1 << WIDTH)) begin : g_bad_reset_value
    $error("gray_counter_param: RESET_VALUE out of range for WIDTH");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] gray_r;
  logic             term_r;
  logic [WIDTH-1:0] cnt_next;
  logic             term_next;

  gray_next_logic #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .cnt        (cnt),
    .up_down    (up_down),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .cnt_next   (cnt_next),
    .term_next  (term_next)
  );

  // Binary and Gray registers update on the same edge so they are never skewed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= RST_BIN;
      gray_r <= RST_GRAY;
      term_r <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      gray_r <= WIDTH'(bin2gray(MAX_WIDTH'(cnt_next)));
      term_r <= term_next;
    end
  end

  assign bin_out    = cnt;
  assign gray_out   = gray_r;
  assign term_pulse = term_r;
  assign at_limit   = up_down ? (cnt == MAX_VAL) : (cnt == '0);

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench: three counter configurations driven by shared stimulus,
// each compared against an integer behavioural model.
module tb_gray_counter_param;
  import gray_pkg::*;

  localparam int unsigned RV8 = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        up_down = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;

  logic [4:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       al [3];
  logic       tp [3];
  logic [15:0] gray_o [3];
  logic [15:0] bin_o  [3];

  int mw [3] = '{5, 5, 8};
  int ms [3] = '{0, 1, 0};
  int mr [3] = '{0, 0, RV8};
  int m_cnt [3];
  int m_term [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(5), .SATURATE(1'b0), .RESET_VALUE(0)) dut_w5 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[4:0]), .gray_out(g0), .bin_out(b0),
    .at_limit(al[0]), .term_pulse(tp[0]));

  gray_counter_param #(.WIDTH(5), .SATURATE(1'b1), .RESET_VALUE(0)) dut_w5s (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[4:0]), .gray_out(g1), .bin_out(b1),
    .at_limit(al[1]), .term_pulse(tp[1]));

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0), .RESET_VALUE(RV8)) dut_w8 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[7:0]), .gray_out(g2), .bin_out(b2),
    .at_limit(al[2]), .term_pulse(tp[2]));

  assign gray_o[0] = 16'(g0);
  assign gray_o[1] = 16'(g1);
  assign gray_o[2] = 16'(g2);
  assign bin_o[0]  = 16'(b0);
  assign bin_o[1]  = 16'(b1);
  assign bin_o[2]  = 16'(b2);

  function automatic int max_of(input int i);
    return (1 << mw[i]) - 1;
  endfunction

  function automatic logic [15:0] exp_gray(input int i);
    int v;
    v = m_cnt[i];
    return 16'(v ^ (v / 2));
  endfunction

  function automatic logic exp_limit(input int i);
    return (up_down && m_cnt[i] == max_of(i)) || (!up_down && m_cnt[i] == 0);
  endfunction

  // Apply inputs, clock one edge, advance the models, settle 1 time unit after the edge.
  task automatic step(input logic r, input logic l, input logic [15:0] lv,
                      input logic en, input logic ud);
    reset = r; load = l; load_value = lv; enable = en; up_down = ud;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      int mx;
      mx = max_of(i);
      if (r) begin
        m_cnt[i] = mr[i]; m_term[i] = 0;
      end else if (l) begin
        m_cnt[i] = int'(lv) % (mx + 1); m_term[i] = 0;
      end else if (en) begin
        if (ud) begin
          if (m_cnt[i] == mx) begin
            m_term[i] = 1; m_cnt[i] = (ms[i] != 0) ? mx : 0;
          end else begin
            m_term[i] = 0; m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          if (m_cnt[i] == 0) begin
            m_term[i] = 1; m_cnt[i] = (ms[i] != 0) ? 0 : mx;
          end else begin
            m_term[i] = 0; m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end else begin
        m_term[i] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'd9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bin_o[i] !== 16'(mr[i]) || gray_o[i] !== 16'(mr[i] ^ (mr[i] / 2)) || tp[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: bin=%0d gray=%h term=%b expected bin=%0d term=0",
                 i, bin_o[i], gray_o[i], tp[i], mr[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [15:0] prev [3];
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) prev[i] = gray_o[i];
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (bin_o[i] !== 16'(m_cnt[i]) || gray_o[i] !== exp_gray(i) || tp[i] !== m_term[i][0]) begin
          n_fail++;
          $display("FAIL up_count dut%0d step %0d: bin=%0d gray=%h term=%b expected bin=%0d gray=%h term=%0d",
                   i, k, bin_o[i], gray_o[i], tp[i], m_cnt[i], exp_gray(i), m_term[i]);
        end
      end
      for (int i = 0; i < 3; i += 2) begin
        n_checks++;
        if ($countones(prev[i] ^ gray_o[i]) != 1) begin
          n_fail++;
          $display("FAIL gray_one_bit dut%0d step %0d: prev=%h now=%h expected one bit change",
                   i, k, prev[i], gray_o[i]);
        end
        prev[i] = gray_o[i];
      end
      if (k == 31) begin
        n_checks++;
        if (g0 !== 5'b10000 || b0 !== 5'd31) begin
          n_fail++;
          $display("FAIL up_top: gray=%b bin=%0d expected gray=10000 bin=31", g0, b0);
        end
      end
      if (k == 32) begin
        n_checks++;
        if (g0 !== 5'b00000 || tp[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL up_wrap: gray=%b term=%b expected gray=00000 term=1", g0, tp[0]);
        end
      end
      if (k == 33) begin
        n_checks++;
        if (tp[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL up_wrap_pulse_width: term=%b expected 0", tp[0]);
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    step(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    n_checks++;
    if (b0 !== 5'd31 || g0 !== 5'b10000 || tp[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: bin=%0d gray=%b term=%b expected bin=31 gray=10000 term=1", b0, g0, tp[0]);
    end
    n_checks++;
    if (b1 !== 5'd0 || tp[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL down_sat: bin=%0d term=%b expected bin=0 term=1", b1, tp[1]);
    end
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
    n_checks++;
    if (b0 !== 5'd30 || g0 !== 5'b10001 || tp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_next: bin=%0d gray=%b term=%b expected bin=30 gray=10001 term=0", b0, g0, tp[0]);
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b1, 16'd30, 1'b0, 1'b1);
    n_checks++;
    if (b1 !== 5'd30 || al[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load: bin=%0d at_limit=%b expected bin=30 at_limit=0", b1, al[1]);
    end
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
      n_checks++;
      if (b1 !== 5'd31 || g1 !== 5'b10000 || al[1] !== 1'b1 || tp[1] !== (k > 1)) begin
        n_fail++;
        $display("FAIL saturate step %0d: bin=%0d gray=%b at_limit=%b term=%b expected bin=31 at_limit=1 term=%0d",
                 k, b1, g1, al[1], tp[1], (k > 1));
      end
    end
    up_down = 1'b0;
    #1;
    n_checks++;
    if (al[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL at_limit_dir: at_limit=%b expected 0 with up_down=0 at bin 31", al[1]);
    end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b1, 16'd12, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bin_o[i] !== 16'(mr[i])) begin
        n_fail++;
        $display("FAIL prio_reset dut%0d: bin=%0d expected %0d", i, bin_o[i], mr[i]);
      end
    end
    step(1'b0, 1'b1, 16'd12, 1'b1, 1'b1);
    n_checks++;
    if (b0 !== 5'd12 || g0 !== 5'b01010 || tp[0] !== 1'b0 || b2 !== 8'd12) begin
      n_fail++;
      $display("FAIL prio_load: bin=%0d gray=%b term=%b bin8=%0d expected bin=12 gray=01010 term=0",
               b0, g0, tp[0], b2);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b1, 16'd16, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
    n_checks++;
    if (b0 !== 5'd17) begin
      n_fail++;
      $display("FAIL mid_pre: bin=%0d expected 17", b0);
    end
    step(1'b1, 1'b0, 16'd0, 1'b1, 1'b1);
    n_checks++;
    if (b0 !== 5'd0 || b2 !== 8'(RV8) || tp[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: bin=%0d bin8=%0d term=%b expected 0 %0d 0", b0, b2, tp[0], RV8);
    end
    step(1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
    n_checks++;
    if (b0 !== 5'd1 || b2 !== 8'(RV8 + 1) || tp[0] !== 1'b0 || tp[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_resume: bin=%0d bin8=%0d term=%b/%b expected 1 %0d 0/0",
               b0, b2, tp[0], tp[2], RV8 + 1);
    end
  endtask

  task automatic test_dir_toggle();
    step(1'b0, 1'b1, 16'd100, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic ud;
      ud = (k % 2 == 0);
      step(1'b0, 1'b0, 16'd0, 1'b1, ud);
      n_checks++;
      if (b2 !== (ud ? 8'd101 : 8'd100) || 16'(g2) !== bin2gray(16'(b2))) begin
        n_fail++;
        $display("FAIL dir_toggle %0d: bin=%0d gray=%h expected bin=%0d gray consistent",
                 k, b2, g2, ud ? 101 : 100);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      logic r, l, en, ud;
      logic [15:0] lv;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      ud = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0:       lv = 16'h0000;
        1:       lv = 16'hffff;
        default: lv = 16'($urandom);
      endcase
      step(r, l, lv, en, ud);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (bin_o[i] !== 16'(m_cnt[i]) || gray_o[i] !== exp_gray(i) || tp[i] !== m_term[i][0]
            || al[i] !== exp_limit(i) || gray2bin(gray_o[i]) !== bin_o[i]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: bin=%0d gray=%h term=%b lim=%b expected bin=%0d gray=%h term=%0d lim=%b",
                   i, k, bin_o[i], gray_o[i], tp[i], al[i], m_cnt[i], exp_gray(i), m_term[i], exp_limit(i));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_term[i] = 0;
    end
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_mid_reset();
    test_dir_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
